uart_tx_fifo: RTL and testbench

- Buffered UART transmitter: the transmit-side counterpart of the UART receive path driven on Rx in TOP_UART.
- Accepts bytes over a valid/ready handshake into an internal FIFO and serialises them on `tx` as 8N1 frames, LSB first.
- Targets the same 66.67 MHz system clock (15 ns period) and 19200 baud link as the receive path.
- Intended to replace direct byte-strobe transmission, so that bursts (for example echo of received data) are not lost while a frame is in flight.

---
 rtl/uart_tx_fifo_if.sv | 19 +
 rtl/uart_tx_fifo.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-stream valid/ready handshake feeding the buffered UART transmitter.
// The master drives data/valid, the slave (transmitter) returns ready.
interface uart_tx_fifo_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: 8N1 frames, LSB first, tx idles high.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 3472,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned CNT_W        = 5
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_fifo_if.slave    in_if,
   output logic             tx,
   output logic             busy,
   output logic             tx_done,
   output logic [CNT_W-1:0] fifo_count
);
   localparam int unsigned      AW        = $clog2(FIFO_DEPTH);
   localparam int unsigned      BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]    BaudLast  = BW'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CountFull = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
   typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

   state_e           state_q, state_d;
   logic [BW-1:0]    baud_q, baud_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       sh_q, sh_d;
   logic             tx_q, tx_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [7:0]       mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   logic       push;
   logic       pop;
   logic       baud_last;
   logic       have_data;
   logic [7:0] head;

   // Ready comes from the registered count only, so a pop while full frees a slot next cycle.
   assign in_if.in_ready = !rst && (count_q != CountFull);
   assign push           = in_if.in_valid && in_if.in_ready;
   assign baud_last      = (baud_q == BaudLast);
   assign have_data      = (count_q != '0);
   assign head           = mem_q[rd_ptr_q];

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q + 1'b1;
      bit_idx_d = bit_idx_q;
      sh_d      = sh_q;
      tx_d      = tx_q;
      pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d     = par_q;
`endif
      unique case (state_q)
         StIdle: begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (have_data) begin
               pop     = 1'b1;
               sh_d    = head;
`ifdef UART_TX_PARITY_EN
               par_d   = ^head;
`endif
               tx_d    = 1'b0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (baud_last) begin
               baud_d    = '0;
               bit_idx_d = '0;
               tx_d      = sh_q[0];
               state_d   = StData;
            end
         end
         StData: begin
            if (baud_last) begin
               baud_d    = '0;
               sh_d      = {1'b0, sh_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = par_q;
                  state_d = StParity;
`else
                  tx_d    = 1'b1;
                  state_d = StStop;
`endif
               end else begin
                  tx_d = sh_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (baud_last) begin
               baud_d  = '0;
               tx_d    = 1'b1;
               state_d = StStop;
            end
         end
`endif
         StStop: begin
            if (baud_last) begin
               baud_d = '0;
               // Chain straight into the next start bit when more data is queued.
               if (have_data) begin
                  pop     = 1'b1;
                  sh_d    = head;
`ifdef UART_TX_PARITY_EN
                  par_d   = ^head;
`endif
                  tx_d    = 1'b0;
                  state_d = StStart;
               end else begin
                  tx_d    = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: begin
            baud_d  = '0;
            tx_d    = 1'b1;
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         baud_q    <= '0;
         bit_idx_q <= '0;
         sh_q      <= '0;
         tx_q      <= 1'b1;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         sh_q      <= sh_d;
         tx_q      <= tx_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
`ifdef UART_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   // Storage needs no reset: only entries counted by count_q are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_if.in_data;
      end
   end

   assign tx         = tx_q;
   assign busy       = (state_q != StIdle);
   assign tx_done    = (state_q == StStop) && baud_last;
   assign fifo_count = count_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model checked every cycle, plus a
// line decoder whose recovered bytes are scored against the accepted-byte queue.
module tb_uart_tx_fifo;
   localparam int unsigned CLKS  = 16;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned CW    = 5;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NBITS = 11;
`else
   localparam int unsigned NBITS = 10;
`endif
   localparam int unsigned FRAME = NBITS * CLKS;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tx;
   logic          busy;
   logic          tx_done;
   logic [CW-1:0] fifo_count;

   uart_tx_fifo_if bus ();

   uart_tx_fifo #(
      .CLKS_PER_BIT(CLKS),
      .FIFO_DEPTH  (DEPTH),
      .CNT_W       (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_if     (bus),
      .tx        (tx),
      .busy      (busy),
      .tx_done   (tx_done),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Line level of bit slot i of a frame carrying byte b.
   function automatic logic exp_bit(input byte unsigned b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
      if (i == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Reference model: a queue of waiting bytes and a frame-position counter.
   byte unsigned mq[$];
   byte unsigned sb[$];
   bit           m_active = 1'b0;
   int           m_t = 0;
   byte unsigned m_cur = 0;
   bit           m_acc = 1'b0;
   bit           m_pop;
   int           m_frames = 0;

   always @(posedge clk) begin
      m_acc = 1'b0;
      if (rst) begin
         mq.delete();
         sb.delete();
         m_active = 1'b0;
         m_t = 0;
      end else begin
         m_acc = bus.in_valid && (mq.size() != DEPTH);
         m_pop = (mq.size() != 0) && (!m_active || m_t == FRAME - 1);
         if (m_active && m_t == FRAME - 1) m_frames++;
         if (m_pop) begin
            m_cur = mq.pop_front();
            m_active = 1'b1;
            m_t = 0;
         end else if (m_active && m_t != FRAME - 1) begin
            m_t++;
         end else begin
            m_active = 1'b0;
         end
         if (m_acc) begin
            mq.push_back(bus.in_data);
            sb.push_back(bus.in_data);
         end
      end
   end

   always @(negedge clk) begin
      check("tx", {31'b0, tx}, {31'b0, m_active ? exp_bit(m_cur, m_t / CLKS) : 1'b1});
      check("busy", {31'b0, busy}, {31'b0, m_active});
      check("tx_done", {31'b0, tx_done}, {31'b0, m_active && m_t == FRAME - 1});
      check("fifo_count", {27'b0, fifo_count}, mq.size());
      check("in_ready", {31'b0, bus.in_ready}, {31'b0, !rst && mq.size() != DEPTH});
   end

   // Line decoder: finds start edges, samples bit centres, scores each recovered byte.
   logic             tx_prev = 1'b1;
   bit               d_active = 1'b0;
   int               d_cnt = 0;
   logic [NBITS-1:0] d_bits;
   int               d_frames = 0;

   always @(negedge clk) begin
      if (rst) begin
         d_active = 1'b0;
      end else if (!d_active) begin
         if (tx_prev === 1'b1 && tx === 1'b0) begin
            d_active = 1'b1;
            d_cnt = 0;
         end
      end else begin
         d_cnt++;
      end
      if (d_active && (d_cnt % CLKS) == CLKS / 2) d_bits[d_cnt / CLKS] = tx;
      if (d_active && d_cnt == FRAME - 1) begin
         d_active = 1'b0;
         d_frames++;
         check("start_bit", {31'b0, d_bits[0]}, 32'd0);
         check("stop_bit", {31'b0, d_bits[NBITS-1]}, 32'd1);
`ifdef UART_TX_PARITY_EN
         check("parity_bit", {31'b0, d_bits[9]}, {31'b0, ^d_bits[8:1]});
`endif
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_data: got %02h, expected no frame (t=%0t)", d_bits[8:1], $time);
         end else begin
            check("frame_data", {24'b0, d_bits[8:1]}, {24'b0, sb.pop_front()});
         end
      end
      tx_prev = tx;
   end

   // Offer a byte and hold it until the model records acceptance; in_valid stays high.
   task automatic push_byte(input byte unsigned b);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 40 * FRAME; c++) begin
         @(posedge clk);
         #2;
         if (m_acc) return;
      end
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: byte %02h not accepted, expected acceptance", b);
   endtask

   task automatic wait_idle(input int budget);
      for (int c = 0; c < budget; c++) begin
         @(posedge clk);
         #2;
         if (!m_active && mq.size() == 0 && !d_active) return;
      end
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", budget);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #2;
      check("reset_tx", {31'b0, tx}, 32'd1);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check("reset_count", {27'b0, fifo_count}, 32'd0);

      // Single byte: tx falls one edge after the push edge.
      push_byte(8'h30);
      bus.in_valid = 1'b0;
      check("latency_push_edge", {31'b0, tx}, 32'd1);
      @(posedge clk);
      #2;
      check("latency_start", {31'b0, tx}, 32'd0);
      wait_idle(2 * FRAME);

      // Back-to-back frames.
      push_byte(8'h27);
      push_byte(8'h31);
      bus.in_valid = 1'b0;
      wait_idle(3 * FRAME);

      // Fill the FIFO while the first frame is in flight.
      for (int i = 0; i < 17; i++) push_byte(byte'(i));
      check("full_count", {27'b0, fifo_count}, 32'd16);
      check("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
      push_byte(8'h11);
      bus.in_valid = 1'b0;
      wait_idle(20 * FRAME);

      // Push and pop on the same edge with three bytes queued.
      for (int i = 0; i < 4; i++) push_byte(byte'(8'h41 + i));
      bus.in_valid = 1'b0;
      check("pushpop_pre_count", {27'b0, fifo_count}, 32'd3);
      for (int c = 0; c < 2 * FRAME && !(m_active && m_t == FRAME - 1); c++) begin
         @(posedge clk);
         #2;
      end
      bus.in_data  = 8'h45;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #2;
      bus.in_valid = 1'b0;
      check("pushpop_count", {27'b0, fifo_count}, 32'd3);
      wait_idle(6 * FRAME);

      // Reset in the middle of the data bits flushes everything.
      for (int i = 0; i < 3; i++) push_byte(byte'(8'hA5 + i));
      bus.in_valid = 1'b0;
      repeat (3 * CLKS) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2;
      check("midframe_rst_tx", {31'b0, tx}, 32'd1);
      check("midframe_rst_count", {27'b0, fifo_count}, 32'd0);
      rst = 1'b0;
      wait_idle(FRAME);

      // Random traffic: a dense phase that saturates the FIFO, then a sparse one.
      for (int c = 0; c < 800; c++) begin
         bus.in_data  = byte'($urandom_range(0, 255));
         bus.in_valid = ($urandom_range(0, 2) == 0);
         @(posedge clk);
         #2;
      end
      for (int c = 0; c < 2500; c++) begin
         bus.in_data  = byte'($urandom_range(0, 255));
         bus.in_valid = ($urandom_range(0, 119) == 0);
         @(posedge clk);
         #2;
      end
      bus.in_valid = 1'b0;
      wait_idle((DEPTH + 2) * FRAME);

      check("scoreboard_empty", sb.size(), 32'd0);
      check("frames_decoded", d_frames, m_frames);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
